// File: rtl/lcd_driver.sv
// HD44780 write-only driver: power-up delay, fixed 8-bit init sequence, then
// one byte per handshake with programmable setup / strobe / hold / execute timing.
module lcd_driver #(
    parameter int T_SETUP   = 4,
    parameter int T_EN_HIGH = 12,
    parameter int T_HOLD    = 4,
    parameter int T_EXEC    = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int T_POWERUP = 750000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    input  logic       cmd_rs_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic       init_done_o,
    output logic       lcd_on_o,
    output logic       lcd_en_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic [7:0] lcd_data_o
);

    localparam int MAX_A   = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
    localparam int MAX_B   = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int MAX_C   = (T_CLEAR > T_POWERUP) ? T_CLEAR : T_POWERUP;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] C_SETUP_END = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_EN_END    = CW'(T_EN_HIGH - 1);
    localparam logic [CW-1:0] C_HOLD_END  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] C_EXEC_END  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] C_CLEAR_END = CW'(T_CLEAR - 1);
    // INIT_LOAD occupies the last cycle of the preceding wait, so each
    // init byte follows the previous one with the same spacing as a command.
    localparam logic [CW-1:0] C_PWR_END   = CW'(T_POWERUP - 2);

    typedef enum logic [2:0] {
        PWRUP,
        INIT_LOAD,
        SETUP,
        EN_HIGH,
        HOLD,
        EXEC_WAIT,
        IDLE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [1:0]    r_init_idx;
    logic [1:0]    w_idx_next;
    logic          r_init_done;
    logic          w_done_next;
    logic          r_rs;
    logic [7:0]    r_data;
    logic          r_on;
    logic          w_load;
    logic          w_load_rs;
    logic [7:0]    w_load_data;
    logic [7:0]    w_init_byte;
    logic          w_clear;
    logic          w_init_more;
    logic [CW-1:0] w_wait_last;

    always_comb begin
        w_init_byte = 8'h38;
        case (r_init_idx)
            2'd0: w_init_byte = 8'h38;
            2'd1: w_init_byte = 8'h0C;
            2'd2: w_init_byte = 8'h01;
            2'd3: w_init_byte = 8'h06;
            default: w_init_byte = 8'h38;
        endcase
    end

    // Clear display / return home need the long execution time.
    assign w_clear     = !r_rs && (r_data == 8'h01 || r_data == 8'h02 || r_data == 8'h03);
    assign w_init_more = !r_init_done && (r_init_idx != 2'd3);
    assign w_wait_last = (w_clear ? C_CLEAR_END : C_EXEC_END) - (w_init_more ? 1'b1 : 1'b0);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_init_idx;
        w_done_next  = r_init_done;
        w_load       = 1'b0;
        w_load_rs    = 1'b0;
        w_load_data  = 8'h00;
        case (r_state)
            PWRUP: begin
                if (r_cnt == C_PWR_END) begin
                    w_state_next = INIT_LOAD;
                    w_cnt_next   = '0;
                    w_idx_next   = 2'd0;
                end
            end
            INIT_LOAD: begin
                w_load       = 1'b1;
                w_load_rs    = 1'b0;
                w_load_data  = w_init_byte;
                w_state_next = SETUP;
                w_cnt_next   = '0;
            end
            SETUP: begin
                if (r_cnt == C_SETUP_END) begin
                    w_state_next = EN_HIGH;
                    w_cnt_next   = '0;
                end
            end
            EN_HIGH: begin
                if (r_cnt == C_EN_END) begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                end
            end
            HOLD: begin
                if (r_cnt == C_HOLD_END) begin
                    w_state_next = EXEC_WAIT;
                    w_cnt_next   = '0;
                end
            end
            EXEC_WAIT: begin
                if (r_cnt == w_wait_last) begin
                    w_cnt_next = '0;
                    if (w_init_more) begin
                        w_state_next = INIT_LOAD;
                        w_idx_next   = r_init_idx + 1'b1;
                    end else begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            IDLE: begin
                w_cnt_next = '0;
                if (cmd_valid_i) begin
                    w_load       = 1'b1;
                    w_load_rs    = cmd_rs_i;
                    w_load_data  = cmd_data_i;
                    w_state_next = SETUP;
                end
            end
            default: begin
                w_state_next = PWRUP;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= PWRUP;
            r_cnt       <= '0;
            r_init_idx  <= 2'd0;
            r_init_done <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_on        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_init_idx  <= w_idx_next;
            r_init_done <= w_done_next;
            r_on        <= 1'b1;
            if (w_load) begin
                r_rs   <= w_load_rs;
                r_data <= w_load_data;
            end
        end
    end

    assign cmd_ready_o = (r_state == IDLE);
    assign init_done_o = r_init_done;
    assign lcd_on_o    = r_on;
    assign lcd_en_o    = (r_state == EN_HIGH);
    assign lcd_rs_o    = r_rs;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = r_data;

endmodule
